// File: rtl/blinky_pkg.sv
// Shared types and constants for the multi-channel Wishbone LED blinker.
package blinky_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_LOOP    = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chan_state_t;

  // Value of the ADR_I MSB that selects the mode register (0 selects pattern).
  localparam logic ADR_SEL_MODE = 1'b1;

  // The unused encoding 3 folds to OFF.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_LOOP;
      2'd2:    return MODE_ONESHOT;
      default: return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/blinky_channel.sv
// One LED channel: pattern/rotate registers, bit counter and IDLE/RUN/DONE FSM.
module blinky_channel
  import blinky_pkg::*;
#(
  parameter int MASK_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 wr_pat,
  input  logic                 wr_mode,
  input  logic [MASK_BITS-1:0] wdata,
  output logic                 led,
  output logic [MASK_BITS-1:0] shreg,
  output chan_state_t          state,
  output mode_t                mode
);

  localparam int STEP_W = $clog2(MASK_BITS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MASK_BITS - 1);

  logic [MASK_BITS-1:0] pattern_q, pattern_d;
  logic [MASK_BITS-1:0] shreg_q, shreg_d;
  logic [STEP_W-1:0]    step_q, step_d;
  mode_t                mode_q, mode_d;
  chan_state_t          state_q, state_d;
  logic                 led_q, led_d;

  // A bus write always takes precedence over a coincident tick.
  always_comb begin
    pattern_d = pattern_q;
    shreg_d   = shreg_q;
    step_d    = step_q;
    mode_d    = mode_q;
    state_d   = state_q;
    led_d     = led_q;
    if (wr_pat) begin
      pattern_d = wdata;
      shreg_d   = wdata;
      step_d    = '0;
      led_d     = 1'b0;
      state_d   = (mode_q != MODE_OFF) ? ST_RUN : ST_IDLE;
    end else if (wr_mode) begin
      mode_d  = decode_mode(wdata[1:0]);
      shreg_d = pattern_q;
      step_d  = '0;
      led_d   = 1'b0;
      state_d = (mode_d != MODE_OFF) ? ST_RUN : ST_IDLE;
    end else if (tick) begin
      case (state_q)
        ST_RUN: begin
          led_d   = shreg_q[MASK_BITS-1];
          shreg_d = {shreg_q[MASK_BITS-2:0], shreg_q[MASK_BITS-1]};
          if (step_q == LAST_STEP) begin
            step_d = '0;
            if (mode_q == MODE_ONESHOT) state_d = ST_DONE;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        default: led_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      shreg_q   <= '0;
      step_q    <= '0;
      mode_q    <= MODE_OFF;
      state_q   <= ST_IDLE;
      led_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      shreg_q   <= shreg_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      state_q   <= state_d;
      led_q     <= led_d;
    end
  end

  assign led   = led_q;
  assign shreg = shreg_q;
  assign state = state_q;
  assign mode  = mode_q;

endmodule

// File: rtl/wish_blinky_mc.sv
// Wishbone-attached multi-channel LED blinker: prescaler, address decode,
// single-cycle ACK, registered readback and NUM_CH channel instances.
module wish_blinky_mc
  import blinky_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int MASK_BITS       = 8,
  parameter int SYSCLK_DIV_BITS = 22,
  localparam int AW             = $clog2(NUM_CH) + 1
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 CYC_I,
  input  logic                 STB_I,
  input  logic                 WE_I,
  input  logic [AW-1:0]        ADR_I,
  input  logic [MASK_BITS-1:0] DAT_I,
  output logic [MASK_BITS-1:0] DAT_O,
  output logic                 ACK_O,
  output logic                 o_alive,
  output logic [NUM_CH-1:0]    o_led
);

  logic [SYSCLK_DIV_BITS-1:0] ckdiv_q, ckdiv_d;
  logic                       ack_q, ack_d;
  logic [MASK_BITS-1:0]       dat_q, dat_d;

  logic                 tick;
  logic                 req;
  logic                 sel_mode;
  logic [31:0]          ch_idx;
  logic [MASK_BITS-1:0] rd_data;
  logic [NUM_CH-1:0]    wr_pat;
  logic [NUM_CH-1:0]    wr_mode;

  logic [MASK_BITS-1:0] ch_shreg [NUM_CH];
  chan_state_t          ch_state [NUM_CH];
  mode_t                ch_mode  [NUM_CH];

  // Handshake: a request is CYC_I & STB_I while ACK_O is low; it is accepted
  // on that edge and ACK_O (with DAT_O) is high for exactly the next cycle.
  always_comb begin
    tick     = (ckdiv_q == '1);
    req      = CYC_I & STB_I & ~ack_q;
    sel_mode = (ADR_I[AW-1] == ADR_SEL_MODE);
    ch_idx   = '0;
    for (int b = 0; b < AW - 1; b++) ch_idx[b] = ADR_I[b];
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_pat[g]  = req & WE_I & ~sel_mode & (ch_idx == g);
    assign wr_mode[g] = req & WE_I &  sel_mode & (ch_idx == g);

    blinky_channel #(.MASK_BITS(MASK_BITS)) u_chan (
      .clk    (CLK_I),
      .rst_n  (RST_I),
      .tick   (tick),
      .wr_pat (wr_pat[g]),
      .wr_mode(wr_mode[g]),
      .wdata  (DAT_I),
      .led    (o_led[g]),
      .shreg  (ch_shreg[g]),
      .state  (ch_state[g]),
      .mode   (ch_mode[g])
    );
  end

  // Indices with no channel behind them read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 32'(i)) begin
        rd_data = sel_mode ? MASK_BITS'({ch_state[i], ch_mode[i]}) : ch_shreg[i];
      end
    end
  end

  always_comb begin
    ckdiv_d = ckdiv_q + 1'b1;
    ack_d   = req;
    dat_d   = req ? rd_data : dat_q;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ckdiv_q <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      ckdiv_q <= ckdiv_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  assign o_alive = ckdiv_q[SYSCLK_DIV_BITS-1];
  assign ACK_O   = ack_q;
  assign DAT_O   = dat_q;

endmodule

// File: tb/tb_wish_blinky_mc.sv
// Directed bench for wish_blinky_mc (tick every 8 clocks); a 5-channel copy
// exercises the out-of-range channel index.
module tb_wish_blinky_mc;

  logic       clk;
  logic       rst_n;
  logic       cyc, stb, we, sel5;
  logic [3:0] adr;
  logic [7:0] dat;

  logic       stb4, stb5;
  logic       ack, ack5;
  logic [7:0] dat_o, dat_o5;
  logic       alive, alive5;
  logic [3:0] led;
  logic [4:0] led5;

  logic [2:0] cnt;
  int         n_checks;
  int         n_errors;
  logic [7:0] exp_q[$];

  assign stb4 = stb & ~sel5;
  assign stb5 = stb & sel5;

  wish_blinky_mc #(.NUM_CH(4), .MASK_BITS(8), .SYSCLK_DIV_BITS(3)) u_dut (
    .CLK_I(clk), .RST_I(rst_n), .CYC_I(cyc), .STB_I(stb4), .WE_I(we),
    .ADR_I(adr[2:0]), .DAT_I(dat), .DAT_O(dat_o), .ACK_O(ack),
    .o_alive(alive), .o_led(led)
  );

  wish_blinky_mc #(.NUM_CH(5), .MASK_BITS(8), .SYSCLK_DIV_BITS(3)) u_dut5 (
    .CLK_I(clk), .RST_I(rst_n), .CYC_I(cyc), .STB_I(stb5), .WE_I(we),
    .ADR_I(adr), .DAT_I(dat), .DAT_O(dat_o5), .ACK_O(ack5),
    .o_alive(alive5), .o_led(led5)
  );

  // Clock and reset-aware reference count of the prescaler phase.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 3'd0;
    else        cnt <= cnt + 3'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic s5, input logic w, input logic [3:0] a,
                      input logic [7:0] d, output logic [7:0] rdat, output logic rack);
    @(negedge clk);
    sel5 = s5; cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
    @(negedge clk);
    rack = s5 ? ack5 : ack;
    rdat = s5 ? dat_o5 : dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input string tag, input logic s5, input logic [3:0] a, input logic [7:0] d);
    logic [7:0] r;
    logic       k;
    xfer(s5, 1'b1, a, d, r, k);
    check({tag, "_ack"}, 8'(k), 8'h01);
  endtask

  task automatic rd(input string tag, input logic s5, input logic [3:0] a, input logic [7:0] e);
    logic [7:0] r;
    logic       k;
    xfer(s5, 1'b0, a, 8'h00, r, k);
    check({tag, "_ack"}, 8'(k), 8'h01);
    check(tag, r, e);
  endtask

  // Returns at the falling edge just after the next tick edge.
  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (cnt != 3'd0 && n < 16) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_cnt(input logic [2:0] v);
    int n = 0;
    while (cnt != v && n < 16) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [15:0] loop_seq;
    logic [5:0]  ack_pat;
    int          pulses;
    logic [7:0]  e;

    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel5 = 1'b0;
    adr = 4'h0; dat = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ack", 8'(ack), 8'h00);
    check("rst_dat", dat_o, 8'h00);
    check("rst_led", 8'(led), 8'h00);
    check("rst_alive", 8'(alive), 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("alive", 8'(alive), 8'(cnt[2]));
    end

    // LOOP on ch1 with 1010_0000
    loop_seq = 16'b1010_0000_1010_0000;
    wr("loop_m", 1'b0, 4'b0101, 8'h01);
    wr("loop_p", 1'b0, 4'b0001, 8'hA0);
    check("loop_clr", 8'(led[1]), 8'h00);
    for (int k = 0; k < 16; k++) exp_q.push_back(8'(loop_seq[15-k]));
    for (int k = 0; k < 16; k++) begin
      wait_tick();
      e = exp_q.pop_front();
      check("loop_led", 8'(led[1]), e);
      if (k == 2) rd("loop_rd3", 1'b0, 4'b0001, 8'h05);
      if (k == 7) rd("loop_rd8", 1'b0, 4'b0001, 8'hA0);
    end
    rd("loop_mode", 1'b0, 4'b0101, 8'h05);

    // ONESHOT on ch2 with 8'hFF
    wr("os_m", 1'b0, 4'b0110, 8'h02);
    wr("os_p", 1'b0, 4'b0010, 8'hFF);
    for (int k = 0; k < 10; k++) begin
      wait_tick();
      check("os_led", 8'(led[2]), (k < 8) ? 8'h01 : 8'h00);
    end
    rd("os_mode", 1'b0, 4'b0110, 8'h0A);
    rd("os_pat", 1'b0, 4'b0010, 8'hFF);

    // Pattern write to ch0 lands on a tick edge while ch3 loops 1100_0000
    wr("col_m0", 1'b0, 4'b0100, 8'h01);
    wr("col_p0", 1'b0, 4'b0000, 8'h81);
    wr("col_m3", 1'b0, 4'b0111, 8'h01);
    wr("col_p3", 1'b0, 4'b0011, 8'hC0);
    wait_tick();
    check("col_t1", 8'(led[3]), 8'h01);
    wait_tick();
    check("col_t2", 8'(led[3]), 8'h01);
    wait_cnt(3'd6);
    wr("col_wr", 1'b0, 4'b0000, 8'h80);
    check("col_led0", 8'(led[0]), 8'h00);
    check("col_led3", 8'(led[3]), 8'h00);
    rd("col_rd0", 1'b0, 4'b0000, 8'h80);
    rd("col_rd3", 1'b0, 4'b0011, 8'h06);
    wait_tick();
    check("col_nx0", 8'(led[0]), 8'h01);
    check("col_nx3", 8'(led[3]), 8'h00);
    rd("col_nxrd0", 1'b0, 4'b0000, 8'h01);

    // STB held six cycles: ACK every other cycle
    ack_pat = 6'b010101;
    pulses = 0;
    @(negedge clk);
    sel5 = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'b0111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ack_pat", 8'(ack), 8'(ack_pat[i]));
      if (ack) begin
        pulses++;
        check("ack_dat", dat_o, 8'h05);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    check("ack_cnt", 8'(pulses), 8'h03);

    // Out-of-range index 5 on the five-channel instance
    wr("oor_p0", 1'b1, 4'b0000, 8'h3C);
    wr("oor_wp", 1'b1, 4'b0101, 8'hFF);
    wr("oor_wm", 1'b1, 4'b1101, 8'h01);
    rd("oor_rp", 1'b1, 4'b0101, 8'h00);
    rd("oor_rm", 1'b1, 4'b1101, 8'h00);
    for (int ch = 0; ch < 5; ch++) begin
      rd("oor_pat", 1'b1, 4'(ch), (ch == 0) ? 8'h3C : 8'h00);
      rd("oor_mode", 1'b1, 4'(ch) | 4'b1000, 8'h00);
    end
    check("oor_led", 8'(led5), 8'h00);

    // LOOP -> OFF (written as 3) mid-pattern
    wr("mc_p", 1'b0, 4'b0001, 8'hFF);
    wait_tick();
    check("mc_on", 8'(led[1]), 8'h01);
    wr("mc_m", 1'b0, 4'b0101, 8'h03);
    check("mc_clr", 8'(led[1]), 8'h00);
    rd("mc_mode", 1'b0, 4'b0101, 8'h00);
    for (int k = 0; k < 2; k++) begin
      wait_tick();
      check("mc_off", 8'(led[1]), 8'h00);
    end

    // Asynchronous reset mid-pattern
    wr("rs_p", 1'b0, 4'b0010, 8'hFF);
    wait_tick();
    check("rs_on", 8'(led[2]), 8'h01);
    rd("rs_mode", 1'b0, 4'b0110, 8'h06);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rs_led", 8'(led), 8'h00);
    check("rs_ack", 8'(ack), 8'h00);
    check("rs_dat", dat_o, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int ch = 0; ch < 4; ch++) rd("rs_mrd", 1'b0, 4'(ch) | 4'b0100, 8'h00);
    rd("rs_prd", 1'b0, 4'b0010, 8'h00);
    wait_tick();
    check("rs_tick", 8'(led), 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
